// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants used by the fetch stage and its neighbours.
package mips_pkg;

    localparam int unsigned INST_W        = 32;
    localparam logic [31:0] MIPS_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] MIPS_NOP      = 32'h0000_0000;

endpackage : mips_pkg

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, addresses the instruction ROM and holds one
// fetched instruction for decode behind a valid/ready handshake.
module inst_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = MIPS_RESET_PC,
    parameter int unsigned ROM_ADDR_WIDTH = 5
) (
    input  logic              clock,
    input  logic              reset,
    output logic [31:0]       imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_pc_plus4,
    output logic              out_of_window,
    output logic              fetch_fault,
    output logic [31:0]       fetch_count
);

    logic [31:0]       pc_q,    pc_d;
    logic              valid_q, valid_d;
    logic [INST_W-1:0] inst_q,  inst_d;
    logic [31:0]       opc_q,   opc_d;
    logic [31:0]       opc4_q,  opc4_d;
    logic              oow_q,   oow_d;
    logic              fault_q, fault_d;
    logic [31:0]       count_q, count_d;

    logic advance;
    logic accept;

    assign advance = ~fault_q & (~valid_q | out_ready);
    assign accept  = valid_q & out_ready;

    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        opc_d   = opc_q;
        opc4_d  = opc4_q;
        oow_d   = oow_q;
        fault_d = fault_q;
        // A flushed slot that decode takes this cycle is still a handshake.
        count_d = count_q + (accept ? 32'd1 : 32'd0);

        if (redirect_valid) begin
            valid_d = 1'b0;
            if (redirect_target[1:0] == 2'b00) begin
                pc_d = redirect_target;
            end else begin
                fault_d = 1'b1;
            end
        end else if (advance) begin
            inst_d  = imem_data;
            opc_d   = pc_q;
            opc4_d  = pc_q + 32'd4;
            oow_d   = |pc_q[31:ROM_ADDR_WIDTH+2];
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            inst_q  <= MIPS_NOP;
            opc_q   <= '0;
            opc4_q  <= '0;
            oow_q   <= 1'b0;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            opc_q   <= opc_d;
            opc4_q  <= opc4_d;
            oow_q   <= oow_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign imem_addr     = pc_q;
    assign out_valid     = valid_q;
    assign out_inst      = inst_q;
    assign out_pc        = opc_q;
    assign out_pc_plus4  = opc4_q;
    assign out_of_window = oow_q;
    assign fetch_fault   = fault_q;
    assign fetch_count   = count_q;

endmodule : inst_fetch
